// File: rtl/lector_bus_rtc.sv
// Read-cycle controller for the RTC multiplexed address/data bus.
// It sends the address, turns the bus around, strobes RD and captures the returned byte.
module lector_bus_rtc #(
   parameter int T_FASE = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       inicio,
   input  logic [7:0] direccion,
   input  logic [7:0] bus_in,
   output logic [7:0] direccion_out,
   output logic       sel_mux,
   output logic       bus_oe,
   output logic       cs_n,
   output logic       ad_n,
   output logic       wr_n,
   output logic       rd_n,
   output logic [7:0] dato_leido,
   output logic       dato_valido,
   output logic       ocupado
);

   localparam logic [7:0] LAST_CNT = 8'(T_FASE - 1);

   typedef enum logic [2:0] {IDLE, DIR_SET, DIR_HOLD, SEPARA, LEE, FIN} estado_t;

   estado_t    r_state;
   logic [7:0] r_cnt;
   logic       w_fin_fase;

   assign w_fin_fase = (r_cnt == LAST_CNT);

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state       <= IDLE;
         r_cnt         <= 8'd0;
         cs_n          <= 1'b1;
         ad_n          <= 1'b1;
         wr_n          <= 1'b1;
         rd_n          <= 1'b1;
         bus_oe        <= 1'b0;
         sel_mux       <= 1'b0;
         direccion_out <= 8'h00;
         dato_leido    <= 8'h00;
         dato_valido   <= 1'b0;
         ocupado       <= 1'b0;
      end else begin
         // Outputs are registered from the state held before this edge,
         // so rd_n is still low on the edge that samples bus_in.
         cs_n        <= !(r_state == DIR_SET || r_state == DIR_HOLD || r_state == LEE);
         ad_n        <= !(r_state == DIR_SET || r_state == DIR_HOLD);
         wr_n        <= (r_state != DIR_SET);
         rd_n        <= (r_state != LEE);
         bus_oe      <= (r_state == DIR_SET || r_state == DIR_HOLD);
         sel_mux     <= 1'b0;
         dato_valido <= (r_state == FIN);
         ocupado     <= (r_state != IDLE);

         case (r_state)
            IDLE: begin
               r_cnt <= 8'd0;
               if (inicio) begin
                  direccion_out <= direccion;
                  r_state       <= DIR_SET;
               end
            end
            DIR_SET: begin
               if (w_fin_fase) begin
                  r_state <= DIR_HOLD;
                  r_cnt   <= 8'd0;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            DIR_HOLD: begin
               if (w_fin_fase) begin
                  r_state <= SEPARA;
                  r_cnt   <= 8'd0;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            SEPARA: begin
               if (w_fin_fase) begin
                  r_state <= LEE;
                  r_cnt   <= 8'd0;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            LEE: begin
               if (w_fin_fase) begin
                  dato_leido <= bus_in;
                  r_state    <= FIN;
                  r_cnt      <= 8'd0;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            FIN: begin
               r_state <= IDLE;
               r_cnt   <= 8'd0;
            end
            default: begin
               r_state <= IDLE;
               r_cnt   <= 8'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lector_bus_rtc.sv
// Bench for lector_bus_rtc: two instances (T_FASE=4 and 1) share stimulus and are
// compared every cycle against a timeline model of the read transaction.
module tb_lector_bus_rtc;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       inicio = 1'b0;
   logic [7:0] direccion = 8'h00;
   logic [7:0] bus_in = 8'h00;

   logic [7:0] o_dir[2], o_dat[2];
   logic       o_sel[2], o_oe[2], o_cs[2], o_ad[2], o_wr[2], o_rd[2], o_dv[2], o_oc[2];

   int errors = 0;
   int checks = 0;
   bit mon_en = 1'b0;

   always #5 clk = ~clk;

   lector_bus_rtc #(.T_FASE(4)) dut0 (
      .clk(clk), .reset(reset), .inicio(inicio), .direccion(direccion), .bus_in(bus_in),
      .direccion_out(o_dir[0]), .sel_mux(o_sel[0]), .bus_oe(o_oe[0]), .cs_n(o_cs[0]),
      .ad_n(o_ad[0]), .wr_n(o_wr[0]), .rd_n(o_rd[0]), .dato_leido(o_dat[0]),
      .dato_valido(o_dv[0]), .ocupado(o_oc[0]));

   lector_bus_rtc #(.T_FASE(1)) dut1 (
      .clk(clk), .reset(reset), .inicio(inicio), .direccion(direccion), .bus_in(bus_in),
      .direccion_out(o_dir[1]), .sel_mux(o_sel[1]), .bus_oe(o_oe[1]), .cs_n(o_cs[1]),
      .ad_n(o_ad[1]), .wr_n(o_wr[1]), .rd_n(o_rd[1]), .dato_leido(o_dat[1]),
      .dato_valido(o_dv[1]), .ocupado(o_oc[1]));

   function automatic int tval(int k);
      return (k == 0) ? 4 : 1;
   endfunction

   // Phase seen on the outputs n edges after acceptance: 0 idle, 1 addr set,
   // 2 addr hold, 3 turnaround, 4 read, 5 done.
   function automatic int phase(int n, int t);
      if (n < 1 || n > 4*t + 1) return 0;
      if (n <= t)   return 1;
      if (n <= 2*t) return 2;
      if (n <= 3*t) return 3;
      if (n <= 4*t) return 4;
      return 5;
   endfunction

   // Model: off = edges since the last accepted request, -1 when none.
   int         off[2] = '{-1, -1};
   logic [7:0] m_dir[2] = '{8'h00, 8'h00};
   logic [7:0] m_dat[2] = '{8'h00, 8'h00};

   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         int  ob;
         int  t;
         bit  idl;
         t  = tval(k);
         ob = off[k];
         if (!reset) begin
            off[k] = -1; m_dir[k] = 8'h00; m_dat[k] = 8'h00;
         end else begin
            idl    = (ob < 0) || (ob >= 4*t + 1);
            off[k] = (ob < 0) ? -1 : ((ob > 4*t + 1) ? ob : ob + 1);
            if (off[k] == 4*t) m_dat[k] = bus_in;
            if (idl && inicio) begin
               off[k] = 0; m_dir[k] = direccion;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (mon_en) begin
         for (int k = 0; k < 2; k++) begin
            int         p;
            logic [7:0] e_ctl, g_ctl;
            p     = phase(off[k], tval(k));
            // {cs_n, ad_n, wr_n, rd_n, bus_oe, sel_mux, dato_valido, ocupado}
            e_ctl = {!(p == 1 || p == 2 || p == 4), !(p == 1 || p == 2), p != 1, p != 4,
                     (p == 1 || p == 2), 1'b0, p == 5, p != 0};
            g_ctl = {o_cs[k], o_ad[k], o_wr[k], o_rd[k], o_oe[k], o_sel[k], o_dv[k], o_oc[k]};
            checks++;
            if (g_ctl !== e_ctl) begin
               errors++;
               $display("FAIL mon_ctl dut%0d t=%0t got=%b exp=%b", k, $time, g_ctl, e_ctl);
            end
            checks++;
            if (o_dir[k] !== m_dir[k]) begin
               errors++;
               $display("FAIL mon_dir dut%0d t=%0t got=%h exp=%h", k, $time, o_dir[k], m_dir[k]);
            end
            checks++;
            if (o_dat[k] !== m_dat[k]) begin
               errors++;
               $display("FAIL mon_dato dut%0d t=%0t got=%h exp=%h", k, $time, o_dat[k], m_dat[k]);
            end
            checks++;
            if (o_oe[k] === 1'b1 && o_rd[k] === 1'b0) begin
               errors++;
               $display("FAIL mon_contention dut%0d t=%0t bus_oe=1 rd_n=0", k, $time);
            end
         end
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic settle();
      inicio = 1'b0;
      repeat (25) tick();
   endtask

   task automatic test_reset();
      reset = 1'b0; inicio = 1'b1; direccion = 8'h5A; bus_in = 8'hC3;
      repeat (3) begin
         tick();
         for (int k = 0; k < 2; k++) begin
            checks++;
            if ({o_cs[k], o_ad[k], o_wr[k], o_rd[k], o_oe[k], o_sel[k], o_dv[k], o_oc[k]} !== 8'b1111_0000 ||
                o_dir[k] !== 8'h00 || o_dat[k] !== 8'h00) begin
               errors++;
               $display("FAIL reset dut%0d got ctl=%b dir=%h dato=%h exp ctl=11110000 dir=00 dato=00",
                        k, {o_cs[k], o_ad[k], o_wr[k], o_rd[k], o_oe[k], o_sel[k], o_dv[k], o_oc[k]},
                        o_dir[k], o_dat[k]);
            end
         end
      end
      mon_en = 1'b1;
      inicio = 1'b0;
      reset  = 1'b1;
      tick();
   endtask

   task automatic test_single();
      int found = 0, wr_lo = 0, rd_lo = 0;
      direccion = 8'h21; bus_in = 8'h37; inicio = 1'b1;
      tick();
      inicio = 1'b0; direccion = 8'($urandom);
      for (int n = 1; n <= 40; n++) begin
         tick();
         if (o_wr[0] === 1'b0) wr_lo++;
         if (o_rd[0] === 1'b0) rd_lo++;
         if (o_dv[0] === 1'b1) begin found = n; break; end
      end
      checks++;
      if (found != 17) begin errors++; $display("FAIL single_latency got=%0d exp=17", found); end
      checks++;
      if (o_dat[0] !== 8'h37) begin errors++; $display("FAIL single_dato got=%h exp=37", o_dat[0]); end
      checks++;
      if (o_dir[0] !== 8'h21) begin errors++; $display("FAIL single_dir got=%h exp=21", o_dir[0]); end
      checks++;
      if (wr_lo != 4 || rd_lo != 4) begin
         errors++; $display("FAIL single_phase got wr_lo=%0d rd_lo=%0d exp 4/4", wr_lo, rd_lo);
      end
      settle();
   endtask

   task automatic test_addr_stable();
      int found = 0;
      direccion = 8'h21; inicio = 1'b1;
      tick();
      inicio = 1'b0;
      repeat (5) tick();
      direccion = 8'hFF; inicio = 1'b1;
      tick();
      inicio = 1'b0;
      checks++;
      if (o_dir[0] !== 8'h21 || o_oc[0] !== 1'b1) begin
         errors++; $display("FAIL addr_stable got dir=%h oc=%b exp dir=21 oc=1", o_dir[0], o_oc[0]);
      end
      for (int n = 7; n <= 40; n++) begin
         tick();
         if (o_dv[0] === 1'b1) begin found = n; break; end
      end
      checks++;
      if (found != 17 || o_dir[0] !== 8'h21) begin
         errors++; $display("FAIL addr_norestart got n=%0d dir=%h exp n=17 dir=21", found, o_dir[0]);
      end
      settle();
   endtask

   task automatic test_turnaround();
      int bad = 0;
      bus_in = 8'hAA; direccion = 8'($urandom); inicio = 1'b1;
      tick();
      inicio = 1'b0;
      for (int n = 1; n <= 17; n++) begin
         tick();
         if (o_oe[0] === 1'b1 && o_rd[0] === 1'b0) bad++;
         bus_in = (n == 15) ? 8'h55 : 8'hAA;
      end
      checks++;
      if (o_dat[0] !== 8'h55 || o_dv[0] !== 1'b1 || bad != 0) begin
         errors++; $display("FAIL turnaround got dato=%h dv=%b bad=%0d exp dato=55 dv=1 bad=0",
                            o_dat[0], o_dv[0], bad);
      end
      settle();
   endtask

   task automatic test_back_to_back();
      int p1 = 0, p2 = 0, idle_cyc = 0;
      logic [7:0] d1 = 8'h00;
      direccion = 8'h10; inicio = 1'b1;
      tick();
      direccion = 8'h11;
      for (int n = 1; n <= 60; n++) begin
         tick();
         if (p1 != 0 && o_oc[0] === 1'b0) idle_cyc++;
         if (o_dv[0] === 1'b1) begin
            if (p1 == 0) begin p1 = n; d1 = o_dir[0]; end
            else begin p2 = n; break; end
         end
      end
      inicio = 1'b0;
      checks++;
      if (p1 != 17 || p2 != 35) begin
         errors++; $display("FAIL b2b_pulses got p1=%0d p2=%0d exp 17/35", p1, p2);
      end
      checks++;
      if (idle_cyc != 1) begin errors++; $display("FAIL b2b_idle got=%0d exp=1", idle_cyc); end
      checks++;
      if (d1 !== 8'h10 || o_dir[0] !== 8'h11) begin
         errors++; $display("FAIL b2b_dir got %h/%h exp 10/11", d1, o_dir[0]);
      end
      settle();
   endtask

   task automatic test_abort();
      int dv_seen = 0, found = 0;
      bus_in = 8'h99; direccion = 8'($urandom); inicio = 1'b1;
      tick();
      inicio = 1'b0;
      repeat (13) tick();
      reset = 1'b0;
      tick();
      checks++;
      if ({o_cs[0], o_ad[0], o_wr[0], o_rd[0], o_oe[0], o_dv[0]} !== 6'b111100) begin
         errors++; $display("FAIL abort_edge got=%b exp=111100",
                            {o_cs[0], o_ad[0], o_wr[0], o_rd[0], o_oe[0], o_dv[0]});
      end
      reset = 1'b1;
      repeat (20) begin
         tick();
         if (o_dv[0] === 1'b1) dv_seen++;
      end
      checks++;
      if (dv_seen != 0) begin errors++; $display("FAIL abort_novalid got=%0d exp=0", dv_seen); end
      direccion = 8'h42; bus_in = 8'h24; inicio = 1'b1;
      tick();
      inicio = 1'b0;
      for (int n = 1; n <= 10; n++) begin
         tick();
         if (o_dv[1] === 1'b1) begin found = n; break; end
      end
      checks++;
      if (found != 5 || o_dat[1] !== 8'h24) begin
         errors++; $display("FAIL abort_t1_read got n=%0d dato=%h exp n=5 dato=24", found, o_dat[1]);
      end
      settle();
   endtask

   task automatic test_random();
      for (int i = 0; i < 3000; i++) begin
         reset     = ($urandom_range(0, 149) != 0);
         inicio    = ($urandom_range(0, 3) == 0);
         direccion = 8'($urandom);
         bus_in    = 8'($urandom);
         tick();
      end
      reset = 1'b1;
      settle();
   endtask

   initial begin
      test_reset();
      test_single();
      test_addr_stable();
      test_turnaround();
      test_back_to_back();
      test_abort();
      test_random();
      mon_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
